// File: rtl/intr_pkg.sv
// Shared types and helpers for the four-source interrupt controller.
// The FSM enum, default source count and id-width helper live here.
package intr_pkg;

    localparam int N_SRC_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2
    } state_t;

    // Bits needed to number n sources; never less than one so ports stay legal.
    function automatic int id_width(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/prio_enc.sv
// Fixed-priority encoder: the highest set index of req wins.
// Purely combinational; valid is low when no bit is set.
module prio_enc #(
    parameter int N_SRC = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_SRC-1:0] req,
    output logic [ID_W-1:0]  id,
    output logic             valid
);

    always_comb begin
        id    = '0;
        valid = 1'b0;
        // Ascending scan so later (higher) indices overwrite lower ones.
        for (int i = 0; i < N_SRC; i++) begin
            if (req[i]) begin
                id    = ID_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: rising-edge capture into pending, fixed priority
// presentation, and a single-outstanding irq/ack/eoi service handshake.
module intr_ctrl
    import intr_pkg::*;
#(
    parameter int N_SRC = N_SRC_DEF,
    parameter int ID_W  = id_width(N_SRC)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] irq_in,
    input  logic [N_SRC-1:0] mask_in,
    input  logic             ack,
    input  logic             eoi,
    output logic             irq_out,
    output logic [ID_W-1:0]  irq_id,
    output logic             id_valid,
    output logic [N_SRC-1:0] pending_out
);

    state_t            state_reg;
    state_t            state_next;
    logic [N_SRC-1:0]  irq_prev_reg;
    logic [N_SRC-1:0]  pending_reg;
    logic [N_SRC-1:0]  pending_next;
    logic [ID_W-1:0]   svc_id_reg;
    logic [ID_W-1:0]   svc_id_next;
    logic [N_SRC-1:0]  rise;
    logic [N_SRC-1:0]  elig;
    logic [N_SRC-1:0]  clr;
    logic [ID_W-1:0]   enc_id;
    logic              enc_valid;
    logic              take;

    assign rise = irq_in & ~irq_prev_reg;
    assign elig = pending_reg & mask_in;

    prio_enc #(
        .N_SRC (N_SRC),
        .ID_W  (ID_W)
    ) u_prio_enc (
        .req   (elig),
        .id    (enc_id),
        .valid (enc_valid)
    );

    // An ack only counts while something is still eligible; otherwise REQ just exits.
    assign take = (state_reg == REQ) && ack && enc_valid;

    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_clr
            assign clr[gi] = take && (enc_id == ID_W'(gi));
        end
    endgenerate

    // Set after clear: a fresh edge on the source being acked keeps it pending.
    assign pending_next = (pending_reg & ~clr) | rise;
    assign svc_id_next  = take ? enc_id : svc_id_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            irq_prev_reg <= '0;
            pending_reg  <= '0;
            svc_id_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            irq_prev_reg <= irq_in;
            pending_reg  <= pending_next;
            svc_id_reg   <= svc_id_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: if (enc_valid) state_next = REQ;
            REQ: begin
                if (!enc_valid) begin
                    state_next = IDLE;
                end else if (ack) begin
                    state_next = SERV;
                end
            end
            SERV: if (eoi) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        irq_out  = (state_reg == REQ);
        id_valid = (state_reg == SERV);
        irq_id   = (state_reg == SERV) ? svc_id_reg : enc_id;
    end

    assign pending_out = pending_reg;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: each step queues its expected outputs,
// then the scoreboard pops and compares them once the DUT has updated.
module tb_intr_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] irq_in;
    logic [3:0] mask_in;
    logic       ack;
    logic       eoi;
    logic       irq_out;
    logic [1:0] irq_id;
    logic       id_valid;
    logic [3:0] pending_out;

    typedef struct {
        string      tag;
        logic       io;
        logic [1:0] id;
        logic       iv;
        logic [3:0] pend;
    } exp_t;

    exp_t sb[$];
    int   n_checks;
    int   n_pass;
    int   n_fail;

    intr_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .irq_in      (irq_in),
        .mask_in     (mask_in),
        .ack         (ack),
        .eoi         (eoi),
        .irq_out     (irq_out),
        .irq_id      (irq_id),
        .id_valid    (id_valid),
        .pending_out (pending_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic io, input logic [1:0] id,
                              input logic iv, input logic [3:0] pend);
        exp_t e;
        e.tag  = tag;
        e.io   = io;
        e.id   = id;
        e.iv   = iv;
        e.pend = pend;
        sb.push_back(e);
    endtask

    task automatic cmp(input string tag, input string fld, input logic [3:0] obs,
                       input logic [3:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s.%s observed=%b expected=%b", tag, fld, obs, exp_v);
        end
    endtask

    task automatic check();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            cmp(e.tag, "irq_out", {3'b0, irq_out}, {3'b0, e.io});
            cmp(e.tag, "irq_id", {2'b0, irq_id}, {2'b0, e.id});
            cmp(e.tag, "id_valid", {3'b0, id_valid}, {3'b0, e.iv});
            cmp(e.tag, "pending", pending_out, e.pend);
            $display("step %-14s irq_out=%b irq_id=%0d id_valid=%b pending=%b",
                     e.tag, irq_out, irq_id, id_valid, pending_out);
        end
    endtask

    task automatic go(input string tag, input logic io, input logic [1:0] id,
                      input logic iv, input logic [3:0] pend);
        expect_out(tag, io, id, iv, pend);
        step();
        check();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        irq_in   = 4'b0000;
        mask_in  = 4'b1111;
        ack      = 1'b0;
        eoi      = 1'b0;
        #3;
        expect_out("reset", 1'b0, 2'd0, 1'b0, 4'b0000);
        check();
        step();
        rst_n = 1'b1;
        go("idle", 1'b0, 2'd0, 1'b0, 4'b0000);

        // Single source 0
        irq_in = 4'b0001;
        go("s0_edge", 1'b0, 2'd0, 1'b0, 4'b0001);
        go("s0_req", 1'b1, 2'd0, 1'b0, 4'b0001);
        ack = 1'b1;
        go("s0_ack", 1'b0, 2'd0, 1'b1, 4'b0000);
        ack = 1'b0; eoi = 1'b1;
        go("s0_eoi", 1'b0, 2'd0, 1'b0, 4'b0000);
        eoi = 1'b0; irq_in = 4'b0000;
        go("s0_quiet", 1'b0, 2'd0, 1'b0, 4'b0000);

        // Preemption before ack
        irq_in = 4'b0010;
        go("pre_s1_edge", 1'b0, 2'd1, 1'b0, 4'b0010);
        go("pre_s1_req", 1'b1, 2'd1, 1'b0, 4'b0010);
        irq_in = 4'b1010;
        go("pre_s3", 1'b1, 2'd3, 1'b0, 4'b1010);
        ack = 1'b1;
        go("pre_ack3", 1'b0, 2'd3, 1'b1, 4'b0010);
        ack = 1'b0; eoi = 1'b1;
        go("pre_eoi3", 1'b0, 2'd1, 1'b0, 4'b0010);
        eoi = 1'b0;
        go("pre_req1", 1'b1, 2'd1, 1'b0, 4'b0010);
        ack = 1'b1;
        go("pre_ack1", 1'b0, 2'd1, 1'b1, 4'b0000);
        ack = 1'b0; eoi = 1'b1;
        go("pre_eoi1", 1'b0, 2'd0, 1'b0, 4'b0000);
        eoi = 1'b0; irq_in = 4'b0000;
        go("pre_quiet", 1'b0, 2'd0, 1'b0, 4'b0000);

        // Masking, then mask removed while in REQ
        mask_in = 4'b1011; irq_in = 4'b0100;
        go("mask_edge", 1'b0, 2'd0, 1'b0, 4'b0100);
        go("mask_hold", 1'b0, 2'd0, 1'b0, 4'b0100);
        mask_in = 4'b1111;
        go("mask_open", 1'b1, 2'd2, 1'b0, 4'b0100);
        mask_in = 4'b1011; ack = 1'b1;
        go("mask_drop", 1'b0, 2'd0, 1'b0, 4'b0100);
        ack = 1'b0;

        // Set/clear collision on source 2
        mask_in = 4'b1111; irq_in = 4'b0000;
        go("col_req", 1'b1, 2'd2, 1'b0, 4'b0100);
        irq_in = 4'b0100; ack = 1'b1;
        go("col_ack", 1'b0, 2'd2, 1'b1, 4'b0100);
        ack = 1'b0; eoi = 1'b1;
        go("col_eoi", 1'b0, 2'd2, 1'b0, 4'b0100);
        eoi = 1'b0;
        go("col_req2", 1'b1, 2'd2, 1'b0, 4'b0100);
        ack = 1'b1;
        go("col_ack2", 1'b0, 2'd2, 1'b1, 4'b0000);
        ack = 1'b0; eoi = 1'b1;
        go("col_eoi2", 1'b0, 2'd0, 1'b0, 4'b0000);
        eoi = 1'b0; irq_in = 4'b0000;
        go("col_quiet", 1'b0, 2'd0, 1'b0, 4'b0000);

        // Held level on source 0: exactly one service
        irq_in = 4'b0001;
        go("lvl_edge", 1'b0, 2'd0, 1'b0, 4'b0001);
        go("lvl_req", 1'b1, 2'd0, 1'b0, 4'b0001);
        ack = 1'b1;
        go("lvl_ack", 1'b0, 2'd0, 1'b1, 4'b0000);
        ack = 1'b0;
        eoi = 1'b0;
        go("lvl_serv", 1'b0, 2'd0, 1'b1, 4'b0000);
        eoi = 1'b1;
        go("lvl_eoi", 1'b0, 2'd0, 1'b0, 4'b0000);
        eoi = 1'b0;
        go("lvl_none1", 1'b0, 2'd0, 1'b0, 4'b0000);
        go("lvl_none2", 1'b0, 2'd0, 1'b0, 4'b0000);
        irq_in = 4'b0000;

        // Reset mid-service
        irq_in = 4'b1000;
        go("rst_edge", 1'b0, 2'd3, 1'b0, 4'b1000);
        go("rst_req", 1'b1, 2'd3, 1'b0, 4'b1000);
        ack = 1'b1;
        go("rst_ack", 1'b0, 2'd3, 1'b1, 4'b0000);
        ack = 1'b0; irq_in = 4'b1001;
        go("rst_serv", 1'b0, 2'd3, 1'b1, 4'b0001);
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("rst_async", 1'b0, 2'd0, 1'b0, 4'b0000);
        check();
        irq_in = 4'b0000;
        go("rst_held", 1'b0, 2'd0, 1'b0, 4'b0000);
        rst_n = 1'b1;
        ack = 1'b1; eoi = 1'b1;
        go("rst_idle", 1'b0, 2'd0, 1'b0, 4'b0000);
        ack = 1'b0; eoi = 1'b0;
        go("rst_idle2", 1'b0, 2'd0, 1'b0, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
